// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM with retired-instruction counter
// Optional illegal-opcode trap state enabled by `define ILLEGAL_OP_TRAP_EN.
module mips_mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             branch_ne,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             trap,
   output logic [3:0]       state_o
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      ADDI_EX   = 4'd11,
      ADDI_WB   = 4'd12,
      TRAP      = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t state;
   logic   op_known;

   assign state_o = state;

   always_comb begin
      op_known = 1'b0;
      case (opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: op_known = 1'b1;
         default: op_known = 1'b0;
      endcase
   end

   // Moore decode of the state register; only FETCH strobes and sw completion see mem_ready.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      instr_retired = 1'b0;
      trap          = 1'b0;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: begin
            alu_src_b = 2'b11;
`ifndef ILLEGAL_OP_TRAP_EN
            instr_retired = ~op_known;
`endif
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         MEM_WB: begin
            reg_write     = 1'b1;
            mem_to_reg    = 1'b1;
            instr_retired = 1'b1;
         end
         MEM_WRITE: begin
            mem_write     = 1'b1;
            iord          = 1'b1;
            instr_retired = mem_ready;
         end
         EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         ALU_WB: begin
            reg_write     = 1'b1;
            reg_dst       = 1'b1;
            instr_retired = 1'b1;
         end
         BRANCH: begin
            pc_write_cond = 1'b1;
            branch_ne     = opcode[0];
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_source     = 2'b01;
            instr_retired = 1'b1;
         end
         JUMP: begin
            pc_write      = 1'b1;
            pc_source     = 2'b10;
            instr_retired = 1'b1;
         end
         ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         ADDI_WB: begin
            reg_write     = 1'b1;
            instr_retired = 1'b1;
         end
         TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
            trap = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         retired_cnt <= '0;
      end else begin
         if (instr_retired)
            retired_cnt <= retired_cnt + CNT_W'(1);
         case (state)
            IDLE:     if (run) state <= FETCH;
            FETCH:    if (mem_ready) state <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_RTYPE:       state <= EXECUTE;
                  OP_LW, OP_SW:   state <= MEM_ADDR;
                  OP_BEQ, OP_BNE: state <= BRANCH;
                  OP_J:           state <= JUMP;
                  OP_ADDI:        state <= ADDI_EX;
`ifdef ILLEGAL_OP_TRAP_EN
                  default:        state <= TRAP;
`else
                  default:        state <= run ? FETCH : IDLE;
`endif
               endcase
            end
            MEM_ADDR:  state <= (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) state <= MEM_WB;
            MEM_WRITE: if (mem_ready) state <= run ? FETCH : IDLE;
            EXECUTE:   state <= ALU_WB;
            ADDI_EX:   state <= ADDI_WB;
            MEM_WB, ALU_WB, BRANCH, JUMP, ADDI_WB:
                       state <= run ? FETCH : IDLE;
            TRAP:      state <= TRAP;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed self-checking bench for mips_mc_ctrl
// Honours `define ILLEGAL_OP_TRAP_EN to match the design build.
module tb_mips_mc_ctrl;

   logic        clock;
   logic        reset;
   logic        run;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
   logic        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic        instr_retired;
   logic [31:0] retired_cnt;
   logic        trap;
   logic [3:0]  state_o;
   logic [17:0] ctl_bus;

   int n_checks = 0;
   int n_fail   = 0;

   mips_mc_ctrl #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
      .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .instr_retired(instr_retired), .retired_cnt(retired_cnt),
      .trap(trap), .state_o(state_o)
   );

   assign ctl_bus = {pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source, instr_retired};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; opcode = 6'b000000; mem_ready = 1'b1;
      tick(); tick();
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_ctl", 32'(ctl_bus), 32'd0);
      check("rst_cnt", retired_cnt, 32'd0);
      check("rst_trap", 32'(trap), 32'd0);

      // R-type: 1, 2, 7, 8
      reset = 1'b1; run = 1'b1;
      tick();
      check("r_fetch_state", 32'(state_o), 32'd1);
      check("r_fetch_strobes", 32'({mem_read, ir_write, pc_write, iord}), 32'b1110);
      check("r_fetch_alub", 32'(alu_src_b), 32'b01);
      tick();
      check("r_decode_state", 32'(state_o), 32'd2);
      check("r_decode_alub", 32'(alu_src_b), 32'b11);
      tick();
      check("r_exec_state", 32'(state_o), 32'd7);
      check("r_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_10);
      tick();
      check("r_wb_state", 32'(state_o), 32'd8);
      check("r_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg, instr_retired}), 32'b1101);
      check("r_wb_cnt_before", retired_cnt, 32'd0);
      tick();
      check("r_next_fetch", 32'(state_o), 32'd1);
      check("r_cnt", retired_cnt, 32'd1);

      // lw with three wait cycles in MEM_READ
      opcode = 6'b100011;
      tick();
      check("lw_decode", 32'(state_o), 32'd2);
      tick();
      check("lw_addr_state", 32'(state_o), 32'd3);
      check("lw_addr_alu", 32'({alu_src_a, alu_src_b}), 32'b1_10);
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_ready = 1'b1;
         #1;
         check($sformatf("lw_hold%0d_state", i), 32'(state_o), 32'd4);
         check($sformatf("lw_hold%0d_rd", i), 32'({mem_read, iord, instr_retired}), 32'b110);
         tick();
      end
      check("lw_wb_state", 32'(state_o), 32'd5);
      check("lw_wb_ctl", 32'({reg_write, mem_to_reg, reg_dst, instr_retired}), 32'b1101);
      tick();
      check("lw_cnt", retired_cnt, 32'd2);

      // bne then beq
      opcode = 6'b000101;
      tick(); tick();
      check("bne_state", 32'(state_o), 32'd9);
      check("bne_ctl", 32'({pc_write_cond, branch_ne, alu_op, pc_source, instr_retired}), 32'b1_1_01_01_1);
      tick();
      check("bne_cnt", retired_cnt, 32'd3);
      opcode = 6'b000100;
      tick(); tick();
      check("beq_state", 32'(state_o), 32'd9);
      check("beq_bne_bit", 32'({pc_write_cond, branch_ne}), 32'b10);
      tick();
      check("beq_fetch", 32'(state_o), 32'd1);
      check("beq_cnt", retired_cnt, 32'd4);

      // sw
      opcode = 6'b101011;
      tick(); tick();
      check("sw_addr", 32'(state_o), 32'd3);
      tick();
      check("sw_state", 32'(state_o), 32'd6);
      check("sw_ctl", 32'({mem_write, iord, mem_read, instr_retired}), 32'b1101);
      tick();
      check("sw_cnt", retired_cnt, 32'd5);

      // j
      opcode = 6'b000010;
      tick(); tick();
      check("j_state", 32'(state_o), 32'd10);
      check("j_ctl", 32'({pc_write, pc_source, instr_retired}), 32'b1_10_1);
      tick();
      check("j_cnt", retired_cnt, 32'd6);

      // addi with run dropped before completion
      opcode = 6'b001000;
      tick(); tick();
      check("addi_ex", 32'(state_o), 32'd11);
      run = 1'b0;
      tick();
      check("addi_wb_state", 32'(state_o), 32'd12);
      check("addi_wb_ctl", 32'({reg_write, reg_dst, mem_to_reg, instr_retired}), 32'b1001);
      tick();
      check("addi_idle", 32'(state_o), 32'd0);
      check("addi_cnt", retired_cnt, 32'd7);
      tick();
      check("idle_stays", 32'(state_o), 32'd0);
      check("idle_ctl", 32'(ctl_bus), 32'd0);
      run = 1'b1;
      tick();
      check("restart_fetch", 32'(state_o), 32'd1);

      // illegal opcode
      opcode = 6'b111111;
      tick();
      check("ill_decode", 32'(state_o), 32'd2);
`ifdef ILLEGAL_OP_TRAP_EN
      check("ill_no_retire", 32'(instr_retired), 32'd0);
      tick();
      check("trap_state", 32'(state_o), 32'd13);
      check("trap_flag", 32'(trap), 32'd1);
      check("trap_ctl", 32'(ctl_bus), 32'd0);
      tick();
      check("trap_held", 32'(state_o), 32'd13);
      check("trap_cnt", retired_cnt, 32'd7);
`else
      check("nop_retire", 32'(instr_retired), 32'd1);
      check("nop_trap", 32'(trap), 32'd0);
      tick();
      check("nop_fetch", 32'(state_o), 32'd1);
      check("nop_cnt", retired_cnt, 32'd8);
`endif

      // reset pulse, then async reset in the middle of a lw
      reset = 1'b0;
      tick();
      check("rst2_state", 32'(state_o), 32'd0);
      check("rst2_cnt", retired_cnt, 32'd0);
      check("rst2_trap", 32'(trap), 32'd0);
      reset = 1'b1; opcode = 6'b100011; mem_ready = 1'b1;
      tick(); tick(); tick();
      check("mid_addr", 32'(state_o), 32'd3);
      mem_ready = 1'b0;
      tick();
      check("mid_read", 32'(state_o), 32'd4);
      reset = 1'b0;
      #1;
      check("mid_rst_state", 32'(state_o), 32'd0);
      check("mid_rst_ctl", 32'(ctl_bus), 32'd0);
      check("mid_rst_cnt", retired_cnt, 32'd0);
      tick();
      check("mid_rst_hold", 32'(state_o), 32'd0);
      reset = 1'b1; run = 1'b0; mem_ready = 1'b1;
      tick();
      check("mid_norun", 32'(state_o), 32'd0);
      run = 1'b1;
      tick();
      check("mid_resume", 32'(state_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Multi-cycle control unit that sequences the shared single-memory MIPS datapath inside main_2. It decodes the opcode held in the instruction register and drives per-state datapath controls: PC, IR, memory, register file and ALU muxes. It stalls on memory waits, honours a run/stop request and counts retired instructions. Outputs are Moore: decoded from the state register only, except where gated by mem_ready as stated below.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
run  input  1  1 = keep fetching; sampled in IDLE and at instruction completion
opcode  input  6  IR[31:26]
mem_ready  input  1  memory completes the access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  conditional PC load; datapath loads when zero XOR branch_ne
branch_ne  output  1  0 = beq, 1 = bne
iord  output  1  memory address source: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load
mem_to_reg  output  1  register write data: 1 = MDR, 0 = ALUOut
reg_dst  output  1  1 = rd, 0 = rt
reg_write  output  1  register file write
alu_src_a  output  1  0 = PC, 1 = A
alu_src_b  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_retired  output  1  one-cycle pulse on instruction completion
retired_cnt  output  CNT_W  retired instruction count
trap  output  1  illegal-opcode trap flag
state_o  output  4  current state code (debug)

Behaviour:
- States and codes: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, ALU_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12, TRAP 13.
- Reset (async, any time including mid-instruction): state = IDLE; all control outputs 0; retired_cnt = 0; trap = 0.
- IDLE: all controls 0. Goes to FETCH when run = 1, otherwise stays.
- FETCH:
  - mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 or 000101 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - anything else -> see Optional Feature.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Goes to MEM_READ for opcode 100011, MEM_WRITE for 101011.
- MEM_READ: mem_read = 1, iord = 1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Completion state.
- MEM_WRITE: mem_write = 1, iord = 1. Holds until mem_ready; completes in the cycle mem_ready = 1.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state ALU_WB.
- ALU_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Completion state.
- BRANCH: pc_write_cond = 1, branch_ne = opcode[0], alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01. Completion state.
- JUMP: pc_write = 1, pc_source = 10. Completion state.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Completion state.
- Completion:
  - instr_retired = 1 for that cycle.
  - retired_cnt increments at the following edge and wraps modulo 2^CNT_W.
  - Next state is FETCH if run = 1, IDLE if run = 0.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4 cycles.
- opcode must stay stable from DECODE until completion; the IR is not rewritten outside FETCH.

Optional Feature:
ILLEGAL_OP_TRAP_EN
- Defined: an unknown opcode in DECODE moves to TRAP. In TRAP, trap = 1 and all other controls are 0; nothing retires. TRAP is left only by reset.
- Undefined: an unknown opcode is a NOP. DECODE is treated as a completion state: instr_retired = 1, then FETCH or IDLE per run. TRAP is unreachable and trap is tied 0.

Test Plan:
- Reset low at cycle 3 mid-lw (state MEM_READ) -> state_o = 0, all controls 0, retired_cnt = 0 immediately; resumes only after reset high and run = 1.
- run = 1, mem_ready = 1, opcode 000000 -> state_o sequence 1, 2, 7, 8; instr_retired high in state 8; retired_cnt = 1.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with mem_read = 1 and iord = 1; then MEM_WB with reg_write = 1 and mem_to_reg = 1.
- bne (000101) -> BRANCH with pc_write_cond = 1, branch_ne = 1, alu_op = 01; beq gives branch_ne = 0; 3 cycles each.
- run dropped during an addi -> after ADDI_WB, state goes to IDLE (0) and stays; run = 1 restarts FETCH next cycle.
- opcode 111111: with ILLEGAL_OP_TRAP_EN, trap = 1 and state_o = 13 held; without it, retired pulse in DECODE and return to FETCH.
